apb_modport: RTL and testbench
==============================

# apb_modport

Two-slave APB subsystem: an APB master bridge plus two identical register-file slaves, driven by a simple transfer-request interface. The request side (transfer, READ_WRITE, separate write/read addresses, write data) is produced by the verification driver or a host controller. The master converts each request into an APB SETUP/ACCESS sequence. Read data is returned on apb_read_data_out.

## Interface
Parameters:
- AW, 9, address width; bit AW-1 selects the slave, bits AW-2:0 index the word.
- DW, 8, data width of every slave word and of the data ports.

Ports:
- PCLK  in  1  single clock; all state changes on its rising edge.
- PRESETn  in  1  reset, synchronous and active-high. Asserted = 1 despite the name.
- transfer  in  1  request valid; sampled in IDLE and at the end of ACCESS.
- READ_WRITE  in  1  request direction: 1 = read, 0 = write.
- apb_write_paddr  in  AW  write address.
- apb_read_paddr  in  AW  read address.
- apb_write_data  in  DW  write data.
- apb_read_data_out  out  DW  registered read result.

## Operation
- Internal APB bus: PADDR[AW-1:0], PWDATA, PWRITE, PENABLE, PSEL1, PSEL2, PRDATA, PREADY.
- Slave select:
  - PSEL1 when latched addr[AW-1] = 0.
  - PSEL2 when latched addr[AW-1] = 1.
  - Never both at once.
- Each slave has 2^(AW-1) words of DW bits.
- PREADY is always 1 in ACCESS, so there are zero wait states.
- Master FSM states: IDLE, SETUP, ACCESS.
  - IDLE with transfer=1 → SETUP. In the same edge, latch:
    - direction;
    - address (apb_read_paddr if READ_WRITE=1, else apb_write_paddr);
    - write data.
  - IDLE with transfer=0 → IDLE.
  - SETUP → ACCESS unconditionally.
  - ACCESS, PREADY=1, transfer=1 → SETUP, latching the new request (back-to-back).
  - ACCESS, PREADY=1, transfer=0 → IDLE.
- Bus outputs per state:
  - SETUP: selected PSELx=1, PENABLE=0.
  - ACCESS: selected PSELx=1, PENABLE=1.
  - IDLE: all PSEL and PENABLE = 0.
- Write: the selected slave stores PWDATA at PADDR[AW-2:0] on the edge ending ACCESS. The other slave is untouched.
- Read: the selected slave drives PRDATA combinationally. apb_read_data_out loads PRDATA on the edge ending ACCESS and holds until the next completed read.
- Writes never change apb_read_data_out.
- Inputs change only between requests; latched copies make the bus immune to input changes during SETUP/ACCESS.

## Timing
- Reset (PRESETn=1 at a rising edge):
  - FSM → IDLE.
  - apb_read_data_out = 0.
  - All PSEL/PENABLE = 0.
  - Every word of both slaves = 0.
- No output is ever X/Z after the first reset edge.
- Reset mid-transfer (in SETUP or ACCESS) aborts the transfer: no memory write, no read-data update.
- Latency, with edge 0 = the edge where transfer=1 is sampled in IDLE:
  - edge 1: SETUP → ACCESS.
  - edge 2: write committed, or apb_read_data_out updated.
  - 3 cycles per isolated transfer; 2 cycles per back-to-back transfer.
- A read of a word written in an earlier transfer returns the new value. There is no same-cycle read/write conflict, since transfers are serialized.
- Address wrap: no out-of-range addresses exist, since the full AW-bit space maps onto the two slaves.

## Test plan
- Reset: PRESETn=1 for 2 cycles → apb_read_data_out=0, FSM IDLE. A read of addr 0x005 then returns 0x00.
- Slave 1 write/read: write 0xA5 to 0x010, then read 0x010 → apb_read_data_out=0xA5 at edge 2 of the read. PSEL2 never asserted.
- Slave 2 isolation:
  - Write 0x3C to 0x110 and 0x77 to 0x010.
  - Read 0x110 → 0x3C.
  - Read 0x010 → 0x77.
- Back-to-back: hold transfer=1 across write 0x0FF←0x5A, then read 0x0FF → no IDLE cycle between transfers; read result 0x5A, 2 cycles after the first ACCESS ends.
- Reset mid-write: request write 0x020←0x99, assert PRESETn during ACCESS → a subsequent read of 0x020 returns 0x00.
- Stability: during each SETUP→ACCESS pair, PADDR, PWRITE and PWDATA stay constant, even if the inputs are toggled mid-transfer. The read output holds between reads.

Source files
------------

// File: rtl/apb_modport_if.sv
// Request-side bundle between a host/driver and the apb_modport subsystem.
// The host drives transfer requests and receives the registered read result.
interface apb_modport_if #(
  parameter int AW = 9,
  parameter int DW = 8
);
  logic          transfer;
  logic          READ_WRITE;
  logic [AW-1:0] apb_write_paddr;
  logic [AW-1:0] apb_read_paddr;
  logic [DW-1:0] apb_write_data;
  logic [DW-1:0] apb_read_data_out;

  modport master (
    output transfer, READ_WRITE, apb_write_paddr, apb_read_paddr, apb_write_data,
    input  apb_read_data_out
  );

  modport slave (
    input  transfer, READ_WRITE, apb_write_paddr, apb_read_paddr, apb_write_data,
    output apb_read_data_out
  );
endinterface

// File: rtl/apb_modport.sv
// Two-slave APB subsystem: request-driven APB master bridge plus two zero-wait
// register-file slaves, selected by the top address bit.

module apb_modport_slave #(
  parameter int IW = 8,
  parameter int DW = 8
) (
  input  logic          PCLK,
  input  logic          PRESETn,
  input  logic          psel,
  input  logic          penable,
  input  logic          pwrite,
  input  logic [IW-1:0] addr,
  input  logic [DW-1:0] pwdata,
  output logic [DW-1:0] prdata,
  output logic          pready
);
  logic [DW-1:0] mem [2**IW];

  assign pready = 1'b1;
  assign prdata = mem[addr];

  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      for (int unsigned i = 0; i < 2**IW; i++) mem[i] <= '0;
    end else if (psel && penable && pwrite && pready) begin
      mem[addr] <= pwdata;
    end
  end
endmodule

module apb_modport #(
  parameter int AW = 9,
  parameter int DW = 8
) (
  input logic         PCLK,
  input logic         PRESETn,
  apb_modport_if.slave req
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic          PWRITE;
  logic          PENABLE;
  logic          PSEL1, PSEL2;
  logic [DW-1:0] PRDATA, prdata1, prdata2;
  logic          PREADY, pready1, pready2;
  logic          latch_req, rd_done;
  logic [DW-1:0] rd_q;

  always_comb begin
    state_d   = state_q;
    latch_req = 1'b0;
    rd_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req.transfer) begin
          state_d   = SETUP;
          latch_req = 1'b1;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (PREADY) begin
          rd_done = !PWRITE;
          if (req.transfer) begin
            state_d   = SETUP;
            latch_req = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign PENABLE = (state_q == ACCESS);
  assign PSEL1   = (state_q != IDLE) && !PADDR[AW-1];
  assign PSEL2   = (state_q != IDLE) &&  PADDR[AW-1];
  assign PRDATA  = PADDR[AW-1] ? prdata2 : prdata1;
  assign PREADY  = PADDR[AW-1] ? pready2 : pready1;

  // Read capture uses PRDATA of the finishing transfer even when a new
  // request is latched on the same edge.
  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      state_q <= IDLE;
      PADDR   <= '0;
      PWDATA  <= '0;
      PWRITE  <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      if (latch_req) begin
        PWRITE <= !req.READ_WRITE;
        PADDR  <= req.READ_WRITE ? req.apb_read_paddr : req.apb_write_paddr;
        PWDATA <= req.apb_write_data;
      end
      if (rd_done) rd_q <= PRDATA;
    end
  end

  assign req.apb_read_data_out = rd_q;

  apb_modport_slave #(.IW(AW-1), .DW(DW)) u_slave1 (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .psel    (PSEL1),
    .penable (PENABLE),
    .pwrite  (PWRITE),
    .addr    (PADDR[AW-2:0]),
    .pwdata  (PWDATA),
    .prdata  (prdata1),
    .pready  (pready1)
  );

  apb_modport_slave #(.IW(AW-1), .DW(DW)) u_slave2 (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .psel    (PSEL2),
    .penable (PENABLE),
    .pwrite  (PWRITE),
    .addr    (PADDR[AW-2:0]),
    .pwdata  (PWDATA),
    .prdata  (prdata2),
    .pready  (pready2)
  );
endmodule

// File: tb/tb_apb_modport.sv
// Randomized bench for apb_modport: a flat 2^AW-word memory model predicts
// read results, and a queue of issued requests predicts the APB bus contents.
module tb_apb_modport;
  localparam int AW = 9;
  localparam int DW = 8;

  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  logic PCLK = 1'b0;
  logic PRESETn = 1'b1;
  int   total = 0;
  int   bad = 0;

  logic [DW-1:0] mem_m [2**AW];
  logic [DW-1:0] exp_rd;
  req_t          pend [$];
  req_t          r_mon;

  apb_modport_if #(.AW(AW), .DW(DW)) bus ();

  apb_modport #(.AW(AW), .DW(DW)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .req     (bus)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Every ACCESS phase must carry exactly the oldest outstanding request.
  always @(negedge PCLK) begin
    if (!PRESETn && dut.PENABLE) begin
      if (pend.size() == 0) begin
        chk("unexpected_access", 32'd1, 32'd0);
      end else begin
        r_mon = pend.pop_front();
        chk("paddr", 32'(dut.PADDR), 32'(r_mon.addr));
        chk("pwrite", 32'(dut.PWRITE), 32'(!r_mon.rw));
        if (!r_mon.rw) chk("pwdata", 32'(dut.PWDATA), 32'(r_mon.data));
        chk("psel", {30'd0, dut.PSEL2, dut.PSEL1}, r_mon.addr[AW-1] ? 32'd2 : 32'd1);
      end
    end
  end

  function automatic logic [1:0] bus_phase();
    return {dut.PSEL1 | dut.PSEL2, dut.PENABLE};
  endfunction

  task automatic scramble();
    bus.READ_WRITE      = 1'($urandom);
    bus.apb_write_paddr = AW'($urandom);
    bus.apb_read_paddr  = AW'($urandom);
    bus.apb_write_data  = DW'($urandom);
  endtask

  task automatic present(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_t r;
    scramble();
    bus.transfer   = 1'b1;
    bus.READ_WRITE = rw;
    if (rw) bus.apb_read_paddr = a;
    else begin
      bus.apb_write_paddr = a;
      bus.apb_write_data  = d;
    end
    r.rw = rw; r.addr = a; r.data = d;
    pend.push_back(r);
  endtask

  task automatic commit(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (rw) exp_rd = mem_m[a];
    else    mem_m[a] = d;
  endtask

  task automatic xfer(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    present(rw, a, d);
    @(posedge PCLK); #1;
    bus.transfer = 1'b0;
    scramble();
    chk("setup_phase", 32'(bus_phase()), 32'd2);
    @(posedge PCLK); #1;
    chk("access_phase", 32'(bus_phase()), 32'd3);
    chk("rd_hold", 32'(bus.apb_read_data_out), 32'(exp_rd));
    @(posedge PCLK); #1;
    commit(rw, a, d);
    chk(rw ? "rd_data" : "rd_after_wr", 32'(bus.apb_read_data_out), 32'(exp_rd));
    chk("idle_phase", 32'(bus_phase()), 32'd0);
  endtask

  task automatic b2b(input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic [AW-1:0] ra);
    present(1'b0, wa, wd);
    @(posedge PCLK); #1;
    present(1'b1, ra, DW'($urandom));
    @(posedge PCLK); #1;
    chk("b2b_access1", 32'(bus_phase()), 32'd3);
    @(posedge PCLK); #1;
    commit(1'b0, wa, wd);
    chk("b2b_no_idle", 32'(bus_phase()), 32'd2);
    chk("b2b_rd_hold", 32'(bus.apb_read_data_out), 32'(exp_rd));
    bus.transfer = 1'b0;
    scramble();
    @(posedge PCLK); #1;
    chk("b2b_access2", 32'(bus_phase()), 32'd3);
    @(posedge PCLK); #1;
    commit(1'b1, ra, '0);
    chk("b2b_rd_data", 32'(bus.apb_read_data_out), 32'(exp_rd));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2**AW; i++) mem_m[i] = '0;
    exp_rd = '0;
    pend.delete();
  endtask

  task automatic reset_mid_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    present(1'b0, a, d);
    @(posedge PCLK); #1;
    bus.transfer = 1'b0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    PRESETn = 1'b0;
    model_reset();
    chk("rst_mid_rd", 32'(bus.apb_read_data_out), 32'd0);
    chk("rst_mid_idle", 32'(bus_phase()), 32'd0);
  endtask

  initial begin
    model_reset();
    bus.transfer = 1'b0;
    scramble();
    @(posedge PCLK); @(posedge PCLK); #1;
    chk("reset_rd", 32'(bus.apb_read_data_out), 32'd0);
    chk("reset_idle", 32'(bus_phase()), 32'd0);
    PRESETn = 1'b0;
    @(posedge PCLK); #1;

    xfer(1'b1, 9'h005, '0);
    xfer(1'b0, 9'h010, 8'hA5);
    xfer(1'b1, 9'h010, '0);
    chk("s1_readback", 32'(bus.apb_read_data_out), 32'hA5);
    xfer(1'b0, 9'h110, 8'h3C);
    xfer(1'b0, 9'h010, 8'h77);
    xfer(1'b1, 9'h110, '0);
    chk("s2_readback", 32'(bus.apb_read_data_out), 32'h3C);
    xfer(1'b1, 9'h010, '0);
    chk("s1_after_s2", 32'(bus.apb_read_data_out), 32'h77);
    xfer(1'b0, 9'h020, 8'h11);
    b2b(9'h0FF, 8'h5A, 9'h0FF);
    chk("b2b_value", 32'(bus.apb_read_data_out), 32'h5A);
    xfer(1'b0, 9'h1FF, 8'hEE);
    repeat (3) @(posedge PCLK);
    #1 chk("rd_hold_idle", 32'(bus.apb_read_data_out), 32'h5A);

    reset_mid_write(9'h020, 8'h99);
    xfer(1'b1, 9'h020, '0);
    chk("rst_mid_wr_lost", 32'(bus.apb_read_data_out), 32'h00);
    xfer(1'b1, 9'h110, '0);
    chk("rst_cleared_s2", 32'(bus.apb_read_data_out), 32'h00);

    for (int n = 0; n < 300; n++) begin
      logic [AW-1:0] a1, a2;
      logic [DW-1:0] d;
      a1 = AW'(($urandom_range(0, 1) << (AW - 1)) | $urandom_range(0, 15));
      a2 = AW'(($urandom_range(0, 1) << (AW - 1)) | $urandom_range(0, 15));
      d  = DW'($urandom);
      case ($urandom_range(0, 9))
        0, 1, 2, 3: xfer(1'b0, a1, d);
        4, 5, 6:    xfer(1'b1, a1, '0);
        7, 8:       b2b(a1, d, ($urandom_range(0, 1) == 1) ? a1 : a2);
        default:    repeat ($urandom_range(1, 3)) @(posedge PCLK);
      endcase
      #0;
    end

    @(posedge PCLK); #1;
    chk("pend_drained", 32'(pend.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
